// File: rtl/johnson_seq_ctrl_if.sv
// Handshake bundle between the CSR/control side and the Johnson sequencing controller.
// The controller attaches through the slave modport and the command issuer through the master modport.
interface johnson_seq_ctrl_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) ();
   localparam int PW = $clog2(2 * N);

   logic             start;
   logic [CNT_W-1:0] rev_count;
   logic             pause;
   logic             abort;
   logic             busy;
   logic [N-1:0]     ring;
   logic [2*N-1:0]   phase;
   logic [PW-1:0]    phase_idx;
   logic             wrap;
   logic             done;
   logic             err;

   modport master (
      output start, rev_count, pause, abort,
      input  busy, ring, phase, phase_idx, wrap, done, err
   );

   modport slave (
      input  start, rev_count, pause, abort,
      output busy, ring, phase, phase_idx, wrap, done, err
   );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Runs an N-stage Johnson ring for a commanded number of revolutions with pause/abort,
// decodes it into one-hot phase enables and recovers from illegal ring patterns.
module johnson_seq_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   johnson_seq_ctrl_if.slave bus
);
   localparam int PW = $clog2(2 * N);
   localparam logic [PW-1:0] LAST_IDX = PW'(2 * N - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t           state_reg, state_next;
   logic [N-1:0]     ring_reg, ring_next;
   logic [CNT_W-1:0] rem_reg, rem_next;
   logic             free_reg, free_next;
   logic             wrap_reg, wrap_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;

   logic [N-1:0]     ring_adv;
   logic [2*N-1:0]   phase_w;
   logic [PW-1:0]    idx_w;
   logic             legal_w;

   // Legal ring pattern for phase k: top k ones for k<=N, otherwise bottom 2N-k ones.
   function automatic logic [N-1:0] phase_pattern(input int k);
      logic [N-1:0] p;
      p = '0;
      for (int b = 0; b < N; b++) begin
         if (k <= N) p[N-1-b] = (b < k);
         else        p[b]     = (b < 2 * N - k);
      end
      return p;
   endfunction

   assign ring_adv = {~ring_reg[0], ring_reg[N-1:1]};

   genvar gi;
   generate
      for (gi = 0; gi < 2 * N; gi++) begin : g_phase
         assign phase_w[gi] = (ring_reg == phase_pattern(gi));
      end
   endgenerate

   always_comb begin
      idx_w = '0;
      for (int k = 0; k < 2 * N; k++) begin
         if (phase_w[k]) idx_w = idx_w | PW'(k);
      end
   end

   assign legal_w = |phase_w;

   always_comb begin
      state_next = state_reg;
      ring_next  = ring_reg;
      rem_next   = rem_reg;
      free_next  = free_reg;
      wrap_next  = 1'b0;
      done_next  = 1'b0;
      err_next   = err_reg;

      if (bus.abort) begin
         state_next = IDLE;
         ring_next  = '0;
      end else if (!legal_w) begin
         // Recovery takes one edge and leaves the FSM where it was.
         ring_next = '0;
         err_next  = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               ring_next = '0;
               if (bus.start) begin
                  state_next = RUN;
                  rem_next   = bus.rev_count;
                  free_next  = (bus.rev_count == '0);
                  err_next   = 1'b0;
               end
            end
            RUN, PAUSE: begin
               if (bus.pause) begin
                  state_next = PAUSE;
               end else begin
                  // Releasing pause advances on the same edge it is seen low.
                  state_next = RUN;
                  ring_next  = ring_adv;
                  if (idx_w == LAST_IDX) begin
                     wrap_next = 1'b1;
                     if (!free_reg) begin
                        rem_next = rem_reg - CNT_W'(1);
                        if (rem_reg == CNT_W'(1)) begin
                           state_next = IDLE;
                           done_next  = 1'b1;
                        end
                     end
                  end
               end
            end
            default: begin
               state_next = IDLE;
               ring_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ring_reg  <= '0;
         rem_reg   <= '0;
         free_reg  <= 1'b0;
         wrap_reg  <= 1'b0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ring_reg  <= ring_next;
         rem_reg   <= rem_next;
         free_reg  <= free_next;
         wrap_reg  <= wrap_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   assign bus.busy      = (state_reg != IDLE);
   assign bus.ring      = ring_reg;
   assign bus.phase     = phase_w;
   assign bus.phase_idx = idx_w;
   assign bus.wrap      = wrap_reg;
   assign bus.done      = done_reg;
   assign bus.err       = err_reg;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: a position-based reference model predicts every
// cycle's outputs, and a negedge monitor pops and compares them.
module tb_johnson_seq_ctrl;
   localparam int N     = 4;
   localparam int CNT_W = 8;
   localparam int PW    = $clog2(2 * N);

   typedef struct {
      int ring;
      int phase;
      int idx;
      int busy;
      int wrap;
      int done;
      int err;
   } exp_t;

   logic clk;
   logic reset;
   exp_t exp_q[$];
   int   errors;
   int   checks;
   int   cycle;
   bit   forced;

   // Reference model: ring position as an integer plus an "illegal" marker.
   int  m_pos;
   bit  m_ill;
   int  m_st;      // 0 idle, 1 run, 2 pause
   int  m_rem;
   bit  m_free;
   bit  m_err;
   bit  m_wrap;
   bit  m_done;

   johnson_seq_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

   johnson_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit i from the top is set while position p lies in (i, i+N].
   function automatic int ring_of(input int p);
      int r;
      r = 0;
      for (int i = 0; i < N; i++) begin
         if (p > i && p <= i + N) r = r | (1 << (N - 1 - i));
      end
      return r;
   endfunction

   task automatic model_step(input bit r, input bit s, input int rc, input bit p,
                             input bit a, input bit f);
      m_wrap = 1'b0;
      m_done = 1'b0;
      if (r) begin
         m_pos = 0; m_ill = 1'b0; m_st = 0; m_rem = 0; m_free = 1'b0; m_err = 1'b0;
      end else if (a) begin
         m_st = 0; m_pos = 0; m_ill = 1'b0;
      end else if (m_ill) begin
         m_ill = 1'b0; m_pos = 0; m_err = 1'b1;
      end else if (m_st == 0) begin
         m_pos = 0;
         if (s) begin
            m_st = 1; m_rem = rc; m_free = (rc == 0); m_err = 1'b0;
         end
      end else if (p) begin
         m_st = 2;
      end else begin
         m_st = 1;
         if (f) begin
            m_ill = 1'b1;
         end else begin
            if (m_pos == 2 * N - 1) begin
               m_wrap = 1'b1;
               if (!m_free) begin
                  m_rem = m_rem - 1;
                  if (m_rem == 0) begin
                     m_st = 0;
                     m_done = 1'b1;
                  end
               end
            end
            m_pos = (m_pos + 1) % (2 * N);
         end
      end
   endtask

   function automatic exp_t model_outputs();
      exp_t e;
      e.ring  = m_ill ? 5 : ring_of(m_pos);
      e.phase = m_ill ? 0 : (1 << m_pos);
      e.idx   = m_ill ? 0 : m_pos;
      e.busy  = (m_st != 0) ? 1 : 0;
      e.wrap  = m_wrap ? 1 : 0;
      e.done  = m_done ? 1 : 0;
      e.err   = m_err ? 1 : 0;
      return e;
   endfunction

   // One clock of stimulus: drive inputs, predict the post-edge outputs, queue them.
   task automatic cyc(input bit r, input bit s, input int rc, input bit p, input bit a, input bit f);
      @(negedge clk);
      #1;
      if (forced) begin
         release dut.ring_adv;
         forced = 1'b0;
      end
      reset         = r;
      bus.start     = s;
      bus.rev_count = CNT_W'(rc);
      bus.pause     = p;
      bus.abort     = a;
      if (f) begin
         force dut.ring_adv = 4'b0101;
         forced = 1'b1;
      end
      model_step(r, s, rc, p, a, f);
      exp_q.push_back(model_outputs());
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cycle, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cycle++;
         $display("cyc %0d ring=%b idx=%0d busy=%0d wrap=%0d done=%0d err=%0d",
                  cycle, bus.ring, bus.phase_idx, bus.busy, bus.wrap, bus.done, bus.err);
         chk("ring",      int'(bus.ring),      e.ring);
         chk("phase",     int'(bus.phase),     e.phase);
         chk("phase_idx", int'(bus.phase_idx), e.idx);
         chk("busy",      int'(bus.busy),      e.busy);
         chk("wrap",      int'(bus.wrap),      e.wrap);
         chk("done",      int'(bus.done),      e.done);
         chk("err",       int'(bus.err),       e.err);
      end
   end

   initial begin
      errors = 0; checks = 0; cycle = 0; forced = 1'b0;
      m_pos = 0; m_ill = 1'b0; m_st = 0; m_rem = 0; m_free = 1'b0; m_err = 1'b0;
      m_wrap = 1'b0; m_done = 1'b0;
      reset = 1'b1; bus.start = 1'b0; bus.rev_count = '0; bus.pause = 1'b0; bus.abort = 1'b0;

      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
      idle_cycles(2);

      // Single revolution
      cyc(0, 1, 1, 0, 0, 0);
      idle_cycles(10);

      // Two revolutions with a 3-cycle pause at ring=1110
      cyc(0, 1, 2, 0, 0, 0);
      for (int i = 0; i < 22; i++) cyc(0, 0, 0, (i >= 3 && i < 6), 0, 0);

      // Abort at ring=0111 in the second revolution, then a fresh single run
      cyc(0, 1, 3, 0, 0, 0);
      for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, (i == 13), 0);
      cyc(0, 1, 1, 0, 0, 0);
      idle_cycles(10);

      // Free-run then abort
      cyc(0, 1, 0, 0, 0, 0);
      idle_cycles(40);
      cyc(0, 0, 0, 0, 1, 0);
      idle_cycles(2);

      // Illegal ring injected mid-run; next accepted start clears err
      cyc(0, 1, 2, 0, 0, 0);
      for (int i = 0; i < 24; i++) cyc(0, 0, 0, 0, 0, (i == 3));
      cyc(0, 1, 1, 0, 0, 0);
      idle_cycles(10);

      // Start while busy is ignored; start+abort in IDLE is dropped
      cyc(0, 1, 1, 0, 0, 0);
      idle_cycles(2);
      cyc(0, 1, 3, 0, 0, 0);
      idle_cycles(8);
      cyc(0, 1, 2, 0, 1, 0);
      idle_cycles(3);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit s, p, a, f;
         int rc;
         s  = ($urandom_range(0, 7) == 0);
         rc = $urandom_range(0, 3);
         p  = ($urandom_range(0, 5) == 0);
         a  = ($urandom_range(0, 39) == 0);
         f  = (m_st != 0) && !m_ill && !p && !a && (m_pos != 2 * N - 1) &&
              ($urandom_range(0, 29) == 0);
         cyc(0, s, rc, p, a, f);
      end
      idle_cycles(2);

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Sequencing controller for the team's N-stage Johnson ring counter. It owns the ring register and runs it for a commanded number of full revolutions (2N states each), with pause and abort. It decodes the ring into one-hot phase enables for downstream multi-phase datapaths and recovers from illegal ring states. It sits between the control/CSR logic, which issues start/abort, and the phase-driven datapath that consumes `phase`.

## Interface
- `N`, 4: ring stages; the sequence length is 2N; N ≥ 2.
- `CNT_W`, 8: width of the revolution count.
- `PW`, $clog2(2*N): width of the phase index; derived, not overridden.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `rev_count`  in  CNT_W  revolutions to run, latched with `start`; 0 = free-run until abort.
- `pause`  in  1  level; holds the ring while high in RUN/PAUSE.
- `abort`  in  1  strobe; returns to IDLE from any state.
- `busy`  out  1  high in RUN or PAUSE.
- `ring`  out  N  Johnson ring register.
- `phase`  out  2N  one-hot decode of `ring`.
- `phase_idx`  out  PW  binary index of the current phase.
- `wrap`  out  1  one-cycle pulse when the ring returns to all-zero during a run.
- `done`  out  1  one-cycle pulse when the commanded revolutions complete.
- `err`  out  1  sticky flag: illegal ring state detected.

## Operation
- Ring update when advancing: ring <= {~ring[0], ring[N-1:1]}. For N=4 the sequence is 0000→1000→1100→1110→1111→0111→0011→0001→0000.
- Phase index k:
  - k=0 for all-zero.
  - k=1..N when the top k bits are 1 and the rest are 0.
  - k=N+1..2N-1 when only the bottom 2N-k bits are 1.
- `phase` = 1<<k; `phase_idx` = k. Both are combinational from `ring`.
- Illegal ring (any of the 2^N−2N other patterns):
  - `phase`=0 and `phase_idx`=0 that cycle.
  - Next edge forces ring=0, sets `err`, counts no wrap.
  - FSM state is unchanged.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: ring held at 0. `start`&~`abort` → RUN; latch rem=`rev_count` and free=(`rev_count`==0); clear `err`.
  - RUN: ring advances every edge unless `pause`=1, which goes to PAUSE with the ring held.
  - PAUSE: ring held; `pause`=0 → RUN, advancing from the following edge.
  - Any state: `abort` → IDLE with ring=0 on the same edge; no `done`; `wrap` suppressed.
- Revolution accounting: on the edge where the ring goes 0001-equivalent (phase 2N−1) → 0 in RUN, `wrap` pulses.
  - If not free: rem decrements. When rem reaches 0, FSM → IDLE and `done` pulses.
  - If free: rem is ignored.
- Priority: reset > abort > pause > advance. `start` outside IDLE is ignored; `rev_count` is not re-sampled.
- Reset values: ring=0, phase=1, phase_idx=0, busy=0, wrap=0, done=0, err=0, state=IDLE, rem=0.

## Timing
- `start` sampled at edge E0: busy=1 after E0, and the ring is still 0 that cycle. The first advance is at E1 (ring=10..0).
- With R=`rev_count`>0 and no pause, the ring returns to 0 at edge E(2N·R). `done` and the final `wrap` are high for the cycle after that edge, with busy=0 in that same cycle. Start-to-done latency is 2N·R cycles, plus one per edge spent with `pause` high.
- `pause` asserted during the cycle before edge Ek: the ring does not change at Ek.
- `abort` at edge Ek: after Ek, ring=0, busy=0, done=0.
- Same-edge `start`+`abort` in IDLE: abort wins and start is dropped.
- `pause` on the final-wrap edge: the ring holds and `done` is deferred until the wrap actually occurs.
- `wrap`/`done` are registered one-cycle pulses and never stretch.

## Test plan
- N=4, `start` with `rev_count`=1 → ring steps through the 8 listed states; after 8 edges `done`=1 and `wrap`=1 for exactly one cycle, busy falls in the same cycle; `phase` walks 0x01→0x02→…→0x80→0x01.
- `rev_count`=2, `pause` held 3 cycles while at ring=1110 → ring holds at 1110 and `phase_idx`=3 for those cycles; `done` arrives 16+3=19 cycles after start; two `wrap` pulses.
- `rev_count`=3, `abort` at ring=0111 in revolution 2 → next cycle ring=0000, busy=0, no `done`; a new `start` with `rev_count`=1 then completes in 8 cycles.
- `rev_count`=0 free-run for 40 cycles → 5 `wrap` pulses, no `done`; `abort` returns to IDLE.
- Force ring=0101 (illegal) mid-run → `phase`=0 that cycle, ring=0000 next edge, `err`=1 sticky, state stays RUN; the next accepted `start` clears `err`.
- `start` pulsed while busy with a different `rev_count` → ignored, and the original count completes; same-edge `start`+`abort` in IDLE → stays IDLE.
